// File: rtl/mshr_pkg.sv
// Shared types and constants for the two-entry miss-status holding registers.
package mshr_pkg;

  localparam int NUM_ENTRIES = 2;
  localparam int ADDR_W      = 32;
  localparam int REGD_W      = 5;

  // Never word-aligned, so an unused tracking slot cannot match a real request.
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic              valid;
    logic              has_ld;
    logic              has_ev;
    logic [ADDR_W-1:0] addr_load;
    logic [ADDR_W-1:0] addr_evict;
    logic [ADDR_W-1:0] evict_data;
    logic [REGD_W-1:0] regD;
    logic              way;
  } entry_t;

endpackage

// File: rtl/mshr_entry.sv
// One MSHR entry: captured miss fields plus the live-slot addresses the cache
// compares against for dependency stalls.
module mshr_entry
  import mshr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc,
  input  logic              clear,
  input  logic              clear_ev,
  input  logic              ld_in,
  input  logic              ev_in,
  input  logic [ADDR_W-1:0] addr_load_in,
  input  logic [ADDR_W-1:0] addr_evict_in,
  input  logic [ADDR_W-1:0] evict_data_in,
  input  logic [REGD_W-1:0] regd_in,
  input  logic              way_in,
  output entry_t            ent,
  output logic [ADDR_W-1:0] slot_load,
  output logic [ADDR_W-1:0] slot_evict
);

  entry_t ent_d, ent_q;

  always_comb begin
    ent_d = ent_q;
    if (alloc) begin
      ent_d.valid      = 1'b1;
      ent_d.has_ld     = ld_in;
      ent_d.has_ev     = ev_in;
      ent_d.addr_load  = addr_load_in;
      ent_d.addr_evict = addr_evict_in;
      ent_d.evict_data = evict_data_in;
      ent_d.regD       = regd_in;
      ent_d.way        = way_in;
    end
    if (clear_ev) begin
      ent_d.has_ev = 1'b0;
    end
    // Freeing keeps the data fields; only the flags matter once invalid.
    if (clear) begin
      ent_d.valid  = 1'b0;
      ent_d.has_ld = 1'b0;
      ent_d.has_ev = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign ent        = ent_q;
  assign slot_load  = ent_q.has_ld ? ent_q.addr_load  : ADDR_INVALID;
  assign slot_evict = ent_q.has_ev ? ent_q.addr_evict : ADDR_INVALID;

endmodule

// File: rtl/mshr.sv
// Two-entry MSHR: allocates load fills / dirty evictions and serialises them,
// oldest entry first, onto a single-port word memory.
//   state  | meaning
//   S_IDLE | no request outstanding; picks the next entry with pending work
//   S_WR   | writeback of the selected entry's dirty line in flight
//   S_RD   | fill read of the selected entry in flight
module mshr
  import mshr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic              evict_valid,
  input  logic [ADDR_W-1:0] addr_load,
  input  logic              load_way_in,
  input  logic [REGD_W-1:0] mshr_regD_in,
  input  logic [ADDR_W-1:0] addr_evict,
  input  logic [ADDR_W-1:0] evict_data,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [ADDR_W-1:0] addr3,
  output logic [ADDR_W-1:0] addr4,
  output logic              mshr_full,
  output logic              mshr_done_pulse,
  output logic [ADDR_W-1:0] mshr_addr_out,
  output logic [ADDR_W-1:0] mshr_data_out,
  output logic [REGD_W-1:0] mshr_regD_out,
  output logic              load_way_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] mem_rdata
);

  entry_t ent0, ent1;
  logic   alloc_req, alloc0, alloc1;
  logic [NUM_ENTRIES-1:0] free_vec, clear_ev_vec, pend;

  seq_state_e        state_d, state_q;
  logic              idx_d, idx_q;
  logic              oldest_d, oldest_q;
  logic              mem_req_d, mem_req_q, mem_we_d, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q, mem_wdata_d, mem_wdata_q;
  logic              done_d, done_q;
  logic [ADDR_W-1:0] fill_addr_d, fill_addr_q, fill_data_d, fill_data_q;
  logic [REGD_W-1:0] fill_regd_d, fill_regd_q;
  logic              fill_way_d, fill_way_q;

  logic              sel_valid, sel_idx, sel_has_ev;
  logic [ADDR_W-1:0] sel_addr_load, sel_addr_evict, sel_evict_data;
  logic              cur_has_ld, cur_way;
  logic [ADDR_W-1:0] cur_addr_load;
  logic [REGD_W-1:0] cur_regd;

  // Lowest free index, judged on state before any same-cycle free.
  assign alloc_req = load_valid | evict_valid;
  assign alloc0    = alloc_req & ~ent0.valid;
  assign alloc1    = alloc_req & ent0.valid & ~ent1.valid;

  mshr_entry u_entry0 (
    .clk, .rst,
    .alloc         (alloc0),
    .clear         (free_vec[0]),
    .clear_ev      (clear_ev_vec[0]),
    .ld_in         (load_valid),
    .ev_in         (evict_valid),
    .addr_load_in  (addr_load),
    .addr_evict_in (addr_evict),
    .evict_data_in (evict_data),
    .regd_in       (mshr_regD_in),
    .way_in        (load_way_in),
    .ent           (ent0),
    .slot_load     (addr1),
    .slot_evict    (addr2)
  );

  mshr_entry u_entry1 (
    .clk, .rst,
    .alloc         (alloc1),
    .clear         (free_vec[1]),
    .clear_ev      (clear_ev_vec[1]),
    .ld_in         (load_valid),
    .ev_in         (evict_valid),
    .addr_load_in  (addr_load),
    .addr_evict_in (addr_evict),
    .evict_data_in (evict_data),
    .regd_in       (mshr_regD_in),
    .way_in        (load_way_in),
    .ent           (ent1),
    .slot_load     (addr3),
    .slot_evict    (addr4)
  );

  assign mshr_full = ent0.valid & ent1.valid;

  assign pend[0]   = ent0.valid & (ent0.has_ld | ent0.has_ev);
  assign pend[1]   = ent1.valid & (ent1.has_ld | ent1.has_ev);
  assign sel_valid = |pend;
  assign sel_idx   = pend[oldest_q] ? oldest_q : ~oldest_q;

  assign sel_has_ev     = sel_idx ? ent1.has_ev     : ent0.has_ev;
  assign sel_addr_load  = sel_idx ? ent1.addr_load  : ent0.addr_load;
  assign sel_addr_evict = sel_idx ? ent1.addr_evict : ent0.addr_evict;
  assign sel_evict_data = sel_idx ? ent1.evict_data : ent0.evict_data;
  assign cur_has_ld     = idx_q ? ent1.has_ld    : ent0.has_ld;
  assign cur_addr_load  = idx_q ? ent1.addr_load : ent0.addr_load;
  assign cur_regd       = idx_q ? ent1.regD      : ent0.regD;
  assign cur_way        = idx_q ? ent1.way       : ent0.way;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = 1'b0;
    fill_addr_d  = '0;
    fill_data_d  = '0;
    fill_regd_d  = '0;
    fill_way_d   = 1'b0;
    free_vec     = '0;
    clear_ev_vec = '0;
    unique case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          idx_d     = sel_idx;
          mem_req_d = 1'b1;
          if (sel_has_ev) begin
            state_d     = S_WR;
            mem_we_d    = 1'b1;
            mem_addr_d  = sel_addr_evict;
            mem_wdata_d = sel_evict_data;
          end else begin
            state_d     = S_RD;
            mem_we_d    = 1'b0;
            mem_addr_d  = sel_addr_load;
            mem_wdata_d = '0;
          end
        end
      end
      S_WR: begin
        if (mem_ack) begin
          clear_ev_vec[idx_q] = 1'b1;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          if (cur_has_ld) begin
            state_d    = S_RD;
            mem_addr_d = cur_addr_load;
          end else begin
            free_vec[idx_q] = 1'b1;
            state_d         = S_IDLE;
            mem_req_d       = 1'b0;
            mem_addr_d      = '0;
          end
        end
      end
      S_RD: begin
        if (mem_ack) begin
          done_d          = 1'b1;
          fill_addr_d     = cur_addr_load;
          fill_data_d     = mem_rdata;
          fill_regd_d     = cur_regd;
          fill_way_d      = cur_way;
          free_vec[idx_q] = 1'b1;
          state_d         = S_IDLE;
          mem_req_d       = 1'b0;
          mem_we_d        = 1'b0;
          mem_addr_d      = '0;
          mem_wdata_d     = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // A new entry is youngest unless the other entry is empty or leaving now.
    oldest_d = oldest_q;
    if (free_vec[oldest_q]) begin
      oldest_d = ~oldest_q;
    end
    if (alloc0) begin
      oldest_d = ent1.valid & ~free_vec[1];
    end
    if (alloc1) begin
      oldest_d = ~(ent0.valid & ~free_vec[0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 1'b0;
      oldest_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      fill_regd_q <= '0;
      fill_way_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      oldest_q    <= oldest_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
      fill_regd_q <= fill_regd_d;
      fill_way_q  <= fill_way_d;
    end
  end

  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mshr_done_pulse = done_q;
  assign mshr_addr_out   = fill_addr_q;
  assign mshr_data_out   = fill_data_q;
  assign mshr_regD_out   = fill_regd_q;
  assign load_way_out    = fill_way_q;

endmodule

// File: tb/tb_mshr.sv
// Self-checking bench for mshr: a transaction-level model with age stamps is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mshr;

  localparam logic [31:0] INV = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0, evict_valid = 1'b0;
  logic [31:0] addr_load = '0, addr_evict = '0, evict_data = '0;
  logic        load_way_in = 1'b0;
  logic [4:0]  mshr_regD_in = '0;
  logic [31:0] addr1, addr2, addr3, addr4;
  logic        mshr_full, mshr_done_pulse, load_way_out;
  logic [31:0] mshr_addr_out, mshr_data_out;
  logic [4:0]  mshr_regD_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mshr dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .evict_valid(evict_valid),
    .addr_load(addr_load), .load_way_in(load_way_in), .mshr_regD_in(mshr_regD_in),
    .addr_evict(addr_evict), .evict_data(evict_data),
    .addr1(addr1), .addr2(addr2), .addr3(addr3), .addr4(addr4),
    .mshr_full(mshr_full), .mshr_done_pulse(mshr_done_pulse),
    .mshr_addr_out(mshr_addr_out), .mshr_data_out(mshr_data_out),
    .mshr_regD_out(mshr_regD_out), .load_way_out(load_way_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting, expected the event to occur (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
  endfunction

  // ---------------- reference model ----------------
  logic        m_v[2], m_ld[2], m_ev[2], m_way[2];
  logic [31:0] m_la[2], m_ea[2], m_ed[2];
  logic [4:0]  m_rd[2];
  int          m_stamp[2];
  int          stamp_ctr = 0;
  bit          m_busy = 0, m_writing = 0;
  int          m_cur = 0;
  logic        e_req = 0, e_we = 0, e_done = 0, e_fway = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_faddr = 0, e_fdata = 0;
  logic [4:0]  e_freg = 0;

  always @(posedge clk or posedge rst) begin : model
    int fi;
    int sel;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_v[i] = 0; m_ld[i] = 0; m_ev[i] = 0; m_way[i] = 0;
        m_la[i] = 0; m_ea[i] = 0; m_ed[i] = 0; m_rd[i] = 0; m_stamp[i] = 0;
      end
      m_busy = 0; m_writing = 0; m_cur = 0;
      e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
      e_done = 0; e_faddr = 0; e_fdata = 0; e_freg = 0; e_fway = 0;
    end else begin
      fi = !m_v[0] ? 0 : (!m_v[1] ? 1 : -1);
      e_done = 0; e_faddr = 0; e_fdata = 0; e_freg = 0; e_fway = 0;
      if (!m_busy) begin
        sel = -1;
        for (int i = 0; i < 2; i++)
          if (m_v[i] && (sel < 0 || m_stamp[i] < m_stamp[sel])) sel = i;
        if (sel >= 0) begin
          m_busy = 1; m_cur = sel; m_writing = m_ev[sel];
          e_req = 1; e_we = m_ev[sel];
          e_addr  = m_ev[sel] ? m_ea[sel] : m_la[sel];
          e_wdata = m_ev[sel] ? m_ed[sel] : 32'h0;
        end
      end else if (mem_ack) begin
        if (m_writing && m_ld[m_cur]) begin
          m_ev[m_cur] = 0; m_writing = 0;
          e_we = 0; e_addr = m_la[m_cur]; e_wdata = 0;
        end else begin
          if (!m_writing) begin
            e_done = 1; e_faddr = m_la[m_cur]; e_fdata = mem_rdata;
            e_freg = m_rd[m_cur]; e_fway = m_way[m_cur];
          end
          m_v[m_cur] = 0; m_ld[m_cur] = 0; m_ev[m_cur] = 0;
          m_busy = 0; m_writing = 0;
          e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
        end
      end
      if ((load_valid || evict_valid) && fi >= 0) begin
        m_v[fi] = 1; m_ld[fi] = load_valid; m_ev[fi] = evict_valid;
        m_la[fi] = addr_load; m_ea[fi] = addr_evict; m_ed[fi] = evict_data;
        m_rd[fi] = mshr_regD_in; m_way[fi] = load_way_in;
        m_stamp[fi] = stamp_ctr; stamp_ctr++;
      end
    end
  end

  always @(negedge clk) begin
    check("mem_req",   32'(mem_req), 32'(e_req));
    check("mem_we",    32'(mem_we), 32'(e_we));
    check("mem_addr",  mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("done",      32'(mshr_done_pulse), 32'(e_done));
    check("fill_addr", mshr_addr_out, e_faddr);
    check("fill_data", mshr_data_out, e_fdata);
    check("fill_regD", 32'(mshr_regD_out), 32'(e_freg));
    check("fill_way",  32'(load_way_out), 32'(e_fway));
    check("full",      32'(mshr_full), 32'(m_v[0] && m_v[1]));
    check("addr1", addr1, (m_v[0] && m_ld[0]) ? m_la[0] : INV);
    check("addr2", addr2, (m_v[0] && m_ev[0]) ? m_ea[0] : INV);
    check("addr3", addr3, (m_v[1] && m_ld[1]) ? m_la[1] : INV);
    check("addr4", addr4, (m_v[1] && m_ev[1]) ? m_ea[1] : INV);
  end

  // ---------------- memory responder and logs ----------------
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  txn_t log_q[$];
  int   ack_delay = 0;
  int   req_age = 0;
  bit   spurious_ack = 0;
  int   pulses = 0;

  always @(negedge clk) begin
    if (mem_ack) req_age = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    if (mem_req && !rst) begin
      if (req_age >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_we ? 32'h0 : mem_val(mem_addr);
        log_q.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
      end else begin
        req_age++;
      end
    end else begin
      req_age = 0;
      if (spurious_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
      end
    end
    if (mshr_done_pulse) pulses++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic alloc(input logic lv, input logic ev, input logic [31:0] la,
                       input logic [31:0] ea, input logic [31:0] ed,
                       input logic [4:0] rd, input logic way);
    load_valid = lv; evict_valid = ev; addr_load = la; addr_evict = ea;
    evict_data = ed; mshr_regD_in = rd; load_way_in = way;
    @(negedge clk);
    load_valid = 1'b0; evict_valid = 1'b0;
  endtask

  task automatic wait_pulse(input string name, input int max, output int cycles);
    cycles = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (mshr_done_pulse) begin
        cycles = i;
        return;
      end
    end
    timeout(name);
  endtask

  task automatic wait_idle(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (!m_busy && !m_v[0] && !m_v[1] && !mem_req && !mshr_done_pulse) return;
      @(negedge clk);
    end
    timeout(name);
  endtask

  task automatic check_log(input string name, input int idx, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (idx >= log_q.size()) begin
      check({name, "_present"}, 32'(log_q.size()), 32'(idx + 1));
    end else begin
      check({name, "_we"},    32'(log_q[idx].we), 32'(we));
      check({name, "_addr"},  log_q[idx].addr, addr);
      check({name, "_wdata"}, log_q[idx].wdata, wdata);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int cyc;
    int p0;
    tick(2);
    rst = 1'b0;
    tick(1);

    // reset values
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_done", 32'(mshr_done_pulse), 32'h0);
    check("rst_full", 32'(mshr_full), 32'h0);
    check("rst_addr1", addr1, INV);
    check("rst_addr4", addr4, INV);

    // load-only miss, memory answers 2 cycles after the request
    log_q.delete(); ack_delay = 2;
    alloc(1, 0, 32'h100, 32'h0, 32'h0, 5'd5, 1'b1);
    check("ld_addr1_c1", addr1, 32'h100);
    wait_pulse("ld_pulse", 20, cyc);
    check("ld_latency", 32'(cyc), 32'd4);
    check("ld_fill_addr", mshr_addr_out, 32'h100);
    check("ld_fill_data", mshr_data_out, 32'hDEAD_BEEF);
    check("ld_fill_regD", 32'(mshr_regD_out), 32'd5);
    check("ld_fill_way", 32'(load_way_out), 32'd1);
    check("ld_addr1_freed", addr1, INV);
    tick(1);
    check("ld_pulse_one_cycle", 32'(mshr_done_pulse), 32'h0);
    check("ld_fill_cleared", mshr_data_out, 32'h0);
    check("ld_log_size", 32'(log_q.size()), 32'd1);
    check_log("ld_rd", 0, 1'b0, 32'h100, 32'h0);

    // load + evict: write completes before the read is issued
    log_q.delete(); ack_delay = 1; p0 = pulses;
    alloc(1, 1, 32'h300, 32'h200, 32'h55, 5'd7, 1'b0);
    check("le_addr1", addr1, 32'h300);
    check("le_addr2", addr2, 32'h200);
    wait_pulse("le_pulse", 20, cyc);
    check("le_fill_addr", mshr_addr_out, 32'h300);
    check("le_fill_data", mshr_data_out, 32'hC0DE_0300);
    wait_idle("le_idle", 20);
    check("le_pulses", 32'(pulses - p0), 32'd1);
    check("le_log_size", 32'(log_q.size()), 32'd2);
    check_log("le_wr", 0, 1'b1, 32'h200, 32'h55);
    check_log("le_rd", 1, 1'b0, 32'h300, 32'h0);

    // evict-only: one write, no pulse
    log_q.delete(); ack_delay = 0; p0 = pulses;
    alloc(0, 1, 32'h0, 32'h400, 32'h77, 5'd0, 1'b0);
    check("ev_addr2", addr2, 32'h400);
    check("ev_addr1", addr1, INV);
    tick(6);
    wait_idle("ev_idle", 20);
    check("ev_pulses", 32'(pulses - p0), 32'd0);
    check("ev_full", 32'(mshr_full), 32'h0);
    check("ev_log_size", 32'(log_q.size()), 32'd1);
    check_log("ev_wr", 0, 1'b1, 32'h400, 32'h77);

    // two loads fill the MSHR, a third is ignored
    log_q.delete(); ack_delay = 1; p0 = pulses;
    alloc(1, 0, 32'h10, 32'h0, 32'h0, 5'd1, 1'b0);
    alloc(1, 0, 32'h20, 32'h0, 32'h0, 5'd2, 1'b1);
    check("two_full", 32'(mshr_full), 32'h1);
    alloc(1, 0, 32'h30, 32'h0, 32'h0, 5'd3, 1'b0);
    check("two_addr1", addr1, 32'h10);
    check("two_addr3", addr3, 32'h20);
    wait_pulse("two_pulse0", 20, cyc);
    check("two_first_addr", mshr_addr_out, 32'h10);
    check("two_full_drop", 32'(mshr_full), 32'h0);
    wait_pulse("two_pulse1", 20, cyc);
    check("two_second_addr", mshr_addr_out, 32'h20);
    check("two_second_way", 32'(load_way_out), 32'd1);
    wait_idle("two_idle", 20);
    check("two_pulses", 32'(pulses - p0), 32'd2);
    check("two_log_size", 32'(log_q.size()), 32'd2);
    check_log("two_rd0", 0, 1'b0, 32'h10, 32'h0);
    check_log("two_rd1", 1, 1'b0, 32'h20, 32'h0);

    // allocation landing on the free edge of the only busy entry
    log_q.delete(); ack_delay = 0;
    alloc(1, 0, 32'h40, 32'h0, 32'h0, 5'd4, 1'b0);
    tick(1);
    alloc(1, 0, 32'h70, 32'h0, 32'h0, 5'd6, 1'b1);
    check("sim_addr3", addr3, 32'h70);
    check("sim_addr1", addr1, INV);
    wait_idle("sim_idle", 20);
    check("sim_log_size", 32'(log_q.size()), 32'd2);
    check_log("sim_rd1", 1, 1'b0, 32'h70, 32'h0);

    // free while full: allocation is dropped
    log_q.delete(); ack_delay = 0;
    alloc(1, 0, 32'h40, 32'h0, 32'h0, 5'd4, 1'b0);
    alloc(1, 0, 32'h50, 32'h0, 32'h0, 5'd8, 1'b0);
    alloc(1, 0, 32'h60, 32'h0, 32'h0, 5'd9, 1'b0);
    wait_idle("busy_idle", 20);
    check("busy_log_size", 32'(log_q.size()), 32'd2);
    check_log("busy_rd0", 0, 1'b0, 32'h40, 32'h0);
    check_log("busy_rd1", 1, 1'b0, 32'h50, 32'h0);

    // mem_ack while idle is ignored
    spurious_ack = 1; tick(3); spurious_ack = 0; tick(1);
    check("spur_req", 32'(mem_req), 32'h0);

    // reset in the middle of a read
    ack_delay = 10; p0 = pulses;
    alloc(1, 0, 32'h600, 32'h0, 32'h0, 5'd3, 1'b0);
    cyc = 0;
    while (!mem_req && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_req_seen", 32'(mem_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req", 32'(mem_req), 32'h0);
    check("rst_mid_addr1", addr1, INV);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    tick(10);
    check("rst_mid_no_pulse", 32'(pulses - p0), 32'd0);
    alloc(1, 0, 32'h500, 32'h0, 32'h0, 5'd11, 1'b1);
    wait_pulse("post_rst_pulse", 20, cyc);
    check("post_rst_latency", 32'(cyc), 32'd2);
    check("post_rst_data", mshr_data_out, 32'hC0DE_0500);
    check("post_rst_regD", 32'(mshr_regD_out), 32'd11);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mshr.md
# mshr

Two-entry miss-status holding register file on the data-cache miss path. Accepts load-miss fills and dirty-line evictions from the data cache, serialises them onto a single-port word memory interface, and returns completed load fills to the cache with a one-cycle done pulse. The cache uses the four exported addresses for dependency stalls and the full flag for capacity stalls.

## Interface
- NUM_ENTRIES, 2: entries. Fixed by the four tracking-address ports; not a free parameter.
- ADDR_W, 32: byte address and data width.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- load_valid  in  1  allocate a load fill. Single-cycle pulse.
- evict_valid  in  1  dirty-line writeback attached to this allocation; may be high with or without load_valid.
- addr_load  in  32  word address to fetch
- load_way_in  in  1  cache way to fill
- mshr_regD_in  in  5  destination register of the load
- addr_evict  in  32  word address to write back
- evict_data  in  32  writeback data
- addr1, addr2, addr3, addr4  out  32  entry0 load, entry0 evict, entry1 load, entry1 evict; slot not live = 32'hFFFF_FFFF
- mshr_full  out  1  both entries valid
- mshr_done_pulse  out  1  load fill complete, one cycle
- mshr_addr_out, mshr_data_out  out  32  fill address and data, valid with the pulse
- mshr_regD_out  out  5  fill destination register
- load_way_out  out  1  fill way
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr, mem_wdata  out  32  request address and write data
- mem_ack  in  1  one-cycle completion of the current request
- mem_rdata  in  32  read data, valid with mem_ack on reads

## Operation
- Allocation happens in any cycle with load_valid | evict_valid and a free entry.
  - The lowest-index free entry is taken.
  - The entry captures all input fields, sets has_ld = load_valid and has_ev = evict_valid, and is stamped youngest.
  - Allocation while mshr_full is ignored: no state change.
- Entry live slots:
  - The load slot drives addr_load while has_ld is set.
  - The evict slot drives addr_evict while has_ev is set.
  - Every other slot drives 32'hFFFF_FFFF. This value is never word-aligned, so it cannot alias a request.
- Age: a 1-bit oldest pointer. Work is selected from the oldest valid entry that still has has_ev or has_ld pending. If that entry has no pending work, the other entry is selected.
- Sequencer FSM, states S_IDLE, S_WR, S_RD:
  - S_IDLE: on a selected entry, go to S_WR if has_ev is set, else S_RD. Latch the entry index.
  - S_WR: drive mem_req=1, mem_we=1, mem_addr=addr_evict, mem_wdata=evict_data. On mem_ack, clear has_ev. Then go to S_RD if has_ld is set; otherwise free the entry and go to S_IDLE.
  - S_RD: drive mem_req=1, mem_we=0, mem_addr=addr_load, mem_wdata=0. On mem_ack, register the fill outputs from mem_rdata and the entry fields, set mshr_done_pulse for the next cycle, free the entry, and go to S_IDLE.
- Evict-only entries produce no done pulse.
- Entry free: clears valid, has_ld and has_ev. If the freed entry was the oldest, the oldest pointer moves to the other entry.
- mem_req, mem_we, mem_addr and mem_wdata are registered state outputs, not decoded combinationally from mem_ack.

## Timing
- Reset values:
  - All entries invalid; sequencer in S_IDLE; oldest pointer = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - mshr_done_pulse = 0, mshr_addr_out = 0, mshr_data_out = 0, mshr_regD_out = 0, load_way_out = 0.
  - mshr_full = 0; addr1–addr4 = FFFF_FFFF.
- Allocation at edge E: the addr slots and mshr_full reflect the new entry in the following cycle (C1).
- Request issue: the sequencer leaves S_IDLE at the end of C1, so mem_req is high in C2. Minimum load latency from allocation to done pulse is 3 cycles with a same-cycle mem_ack.
- Write followed by read: the edge that sees the write mem_ack switches straight to the read. mem_req stays high, with the new address in the next cycle.
- Done pulse: high exactly one cycle, the cycle after the read mem_ack.
  - The entry is already freed in that cycle: its slots read FFFF_FFFF and mshr_full is deasserted.
  - Fill outputs return to 0 after the pulse.
- Simultaneous alloc and free in the same cycle: the free takes effect, and the allocation uses the lowest free index computed before the free. It is only ignored if both entries were busy.
- mem_ack in S_IDLE is ignored.
- rst mid-transaction: all state is cleared asynchronously and the memory request is dropped. Memory is not required to complete it.

## Structure
- Package mshr_pkg holds:
  - entry struct (valid, has_ld, has_ev, addr_load, addr_evict, evict_data, regD, way)
  - sequencer state enum
  - constant ADDR_INVALID = 32'hFFFF_FFFF
- Sub-module mshr_entry: one entry's registers, allocate/clear/clear_ev controls, and slot address outputs. The top level instantiates it twice, plus the sequencer and age logic.

## Test plan
- Reset → all outputs at their reset values; addr1–addr4 = FFFF_FFFF; mshr_full = 0.
- Load-only miss: addr_load = 0x100, regD = 5, way = 1; memory acks 2 cycles after mem_req with rdata 0xDEADBEEF → one read to 0x100, then a single-cycle done pulse with addr 0x100, data 0xDEADBEEF, regD 5, way 1; addr1 back to FFFF_FFFF in the pulse cycle.
- Load + evict: addr_evict 0x200, data 0x55, load 0x300 → write to 0x200 with data 0x55 completes before the read of 0x300 is issued; addr2 clears after the write ack; one done pulse.
- Evict-only (store miss): 0x400, data 0x77 → one write, no done pulse, entry freed.
- Two loads, 0x10 then 0x20, then a third request → mshr_full = 1 and the third request is ignored; reads complete in allocation order; mshr_full drops in the first pulse cycle.
- rst asserted while mem_req is high in S_RD → mem_req is 0 immediately and no done pulse ever appears; a subsequent allocation is serviced normally.
